// File: rtl/cpu_defs_pkg.sv
// Shared opcode, state and IR field definitions for the Phase-1 control path.
package cpu_defs_pkg;

  localparam int unsigned OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 27;
  localparam int unsigned RA_MSB  = 26;
  localparam int unsigned RA_LSB  = 23;
  localparam int unsigned RB_MSB  = 22;
  localparam int unsigned RB_LSB  = 19;
  localparam int unsigned RC_MSB  = 18;
  localparam int unsigned RC_LSB  = 15;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_BINARY, CLS_UNARY, CLS_NOP, CLS_HALT, CLS_UNDEF
  } op_class_t;

  function automatic op_class_t op_class(input logic [OPC_W-1:0] opc);
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_MUL, OP_DIV: return CLS_BINARY;
      OP_NEG, OP_NOT:                 return CLS_UNARY;
      OP_NOP:                         return CLS_NOP;
      OP_HALT:                        return CLS_HALT;
      default:                        return CLS_UNDEF;
    endcase
  endfunction

  function automatic logic is_muldiv(input logic [OPC_W-1:0] opc);
    return (opc == OP_MUL) || (opc == OP_DIV);
  endfunction

endpackage

// File: rtl/reg_field_decoder.sv
// Register field to one-hot enable, with an out-of-range flag for fields beyond NUM_REGS.
module reg_field_decoder #(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic [3:0]          field,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot,
  output logic                out_of_range
);

  always_comb begin
    onehot       = '0;
    out_of_range = 1'b0;
    if (en) begin
      if ({28'd0, field} < NUM_REGS) begin
        onehot[field] = 1'b1;
      end else begin
        out_of_range = 1'b1;
      end
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer driving the Phase-1 datapath strobes.
module control_sequencer
  import cpu_defs_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned OPW      = 5
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [31:0]         ir,
  input  logic                mem_ready,
  input  logic                stop,
  input  logic                resume,
  output logic                pc_out,
  output logic                mar_in,
  output logic                inc_pc,
  output logic                pc_in,
  output logic                read,
  output logic                mdr_in,
  output logic                mdr_out,
  output logic                ir_in,
  output logic                y_in,
  output logic                z_in,
  output logic                zlow_out,
  output logic                zhigh_out,
  output logic                hi_in,
  output logic                lo_in,
  output logic [NUM_REGS-1:0] rin,
  output logic [NUM_REGS-1:0] rout,
  output logic [OPW-1:0]      alu_op,
  output logic                run,
  output logic                illegal
);

  state_t           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [OPC_W-1:0] opc;
  logic [3:0]       ra, rb, rc;
  logic             rin_en, rout_en, rout_sel_rc;
  logic             rin_oor, rout_oor;
  logic             unused_ir_bits;

  assign opc            = ir[OPC_MSB:OPC_LSB];
  assign ra             = ir[RA_MSB:RA_LSB];
  assign rb             = ir[RB_MSB:RB_LSB];
  assign rc             = ir[RC_MSB:RC_LSB];
  assign unused_ir_bits = ^ir[RC_LSB-1:0];

  reg_field_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec (
    .field        (ra),
    .en           (rin_en),
    .onehot       (rin),
    .out_of_range (rin_oor)
  );

  reg_field_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (
    .field        (rout_sel_rc ? rc : rb),
    .en           (rout_en),
    .onehot       (rout),
    .out_of_range (rout_oor)
  );

  always_comb begin
    state_d     = state_q;
    pc_out      = 1'b0;
    mar_in      = 1'b0;
    inc_pc      = 1'b0;
    pc_in       = 1'b0;
    read        = 1'b0;
    mdr_in      = 1'b0;
    mdr_out     = 1'b0;
    ir_in       = 1'b0;
    y_in        = 1'b0;
    z_in        = 1'b0;
    zlow_out    = 1'b0;
    zhigh_out   = 1'b0;
    hi_in       = 1'b0;
    lo_in       = 1'b0;
    rin_en      = 1'b0;
    rout_en     = 1'b0;
    rout_sel_rc = 1'b0;
    alu_op      = '0;
    run         = (state_q != S_RST) && (state_q != S_HALT);

    case (state_q)
      S_RST: state_d = S_T0;
      S_T0: begin
        // A concurrent resume overrides stop so a resumed core makes progress.
        if (stop && !resume) begin
          state_d = S_HALT;
        end else begin
          pc_out  = 1'b1;
          mar_in  = 1'b1;
          inc_pc  = 1'b1;
          z_in    = 1'b1;
          state_d = S_T1;
        end
      end
      S_T1: begin
        zlow_out = 1'b1;
        pc_in    = 1'b1;
        read     = 1'b1;
        if (mem_ready) begin
          mdr_in  = 1'b1;
          state_d = S_T2;
        end else begin
          state_d = S_T1W;
        end
      end
      S_T1W: begin
        read = 1'b1;
        if (mem_ready) begin
          mdr_in  = 1'b1;
          state_d = S_T2;
        end
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        case (op_class(opc))
          CLS_BINARY: begin
            rout_en = 1'b1;
            y_in    = 1'b1;
            state_d = S_T4;
          end
          CLS_UNARY: begin
            rout_en = 1'b1;
            z_in    = 1'b1;
            alu_op  = OPW'(opc);
            state_d = S_T5;
          end
          CLS_HALT: state_d = S_HALT;
          default:  state_d = S_T0;
        endcase
      end
      S_T4: begin
        rout_en     = 1'b1;
        rout_sel_rc = 1'b1;
        z_in        = 1'b1;
        alu_op      = OPW'(opc);
        state_d     = S_T5;
      end
      S_T5: begin
        zlow_out = 1'b1;
        if (is_muldiv(opc)) begin
          lo_in   = 1'b1;
          state_d = S_T6;
        end else begin
          rin_en  = 1'b1;
          state_d = S_T0;
        end
      end
      S_T6: begin
        zhigh_out = 1'b1;
        hi_in     = 1'b1;
        state_d   = S_T0;
      end
      S_HALT: if (resume) state_d = S_T0;
      default: state_d = S_RST;
    endcase
  end

  always_comb begin
    illegal_d = illegal_q;
    if ((state_q == S_T3) && (op_class(opc) == CLS_UNDEF)) illegal_d = 1'b1;
    if (rin_oor || rout_oor) illegal_d = 1'b1;
  end

  assign illegal = illegal_q;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= S_RST;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
